arith_calc_module: RTL and testbench

- Parametrised successor to the board's single-operation multiplier menu block: a four-operation integer calculator (multiply, add, subtract, divide).
- Sits behind the top-level menu mux. Reads switch data on debounced button pulses and drives the 32-character LCD text bus.
- Multiply and divide are multicycle iterative datapaths, not a single-cycle combinational `*`.
- Returns to its start screen on request, so it can be re-run without a reset.

---
 rtl/calc_pkg.sv | 45 ++++
 rtl/iter_muldiv.sv | 115 +++++++++++
 rtl/arith_calc_module.sv | 234 +++++++++++++++++++++++
 tb/tb_arith_calc_module.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the arithmetic calculator menu block:
//   - one-hot FSM state encodings (START, LOAD_A, LOAD_B, CALC, DONE)
//   - operation mode codes as presented on the mode switches
//   - LCD text bus width
//   - nibble-to-ASCII and operation-to-ASCII helpers
// ----------------------------------------------------------------------------
package calc_pkg;

    localparam int unsigned LCD_W = 256;

    localparam logic [4:0] ST_START  = 5'b00001;
    localparam logic [4:0] ST_LOAD_A = 5'b00010;
    localparam logic [4:0] ST_LOAD_B = 5'b00100;
    localparam logic [4:0] ST_CALC   = 5'b01000;
    localparam logic [4:0] ST_DONE   = 5'b10000;

    // Bit positions of the one-hot states that drive status outputs directly
    localparam int unsigned ST_CALC_IDX = 3;
    localparam int unsigned ST_DONE_IDX = 4;

    localparam logic [1:0] MODE_MUL = 2'b00;
    localparam logic [1:0] MODE_ADD = 2'b01;
    localparam logic [1:0] MODE_SUB = 2'b10;
    localparam logic [1:0] MODE_DIV = 2'b11;

    // Hex nibble to uppercase ASCII: 0-9, A-F
    function automatic logic [7:0] bin2x(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    function automatic logic [7:0] op_char(input logic [1:0] op);
        case (op)
            MODE_ADD: return "+";
            MODE_SUB: return "-";
            MODE_DIV: return "/";
            default:  return "*";
        endcase
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// ----------------------------------------------------------------------------
// iter_muldiv
// Iterative unsigned multiply / divide engine. One bit per cycle, WIDTH cycles.
//   Multiply: shift-add, multiplier consumed LSB first.
//   Divide  : restoring division, quotient produced MSB first
//             (only built when ARITH_DIV_EN is defined).
// Ports:
//   Clk, reset  clock, asynchronous active-low reset
//   start       load operands and begin iterating (ignored while busy)
//   op          mode code sampled on start (MODE_DIV divides, anything else multiplies)
//   a, b        multiplicand/dividend and multiplier/divisor
//   busy        iteration in progress
//   fin         high during the last iteration cycle; res is valid in that cycle
//   res         product, or {quotient, remainder} for divide
// ----------------------------------------------------------------------------
module iter_muldiv
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               fin,
    output logic [2*WIDTH-1:0] res
);

    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned CW    = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             r_active;
    logic [CW-1:0]    r_cnt;
    logic [RES_W-1:0] r_acc;
    logic [RES_W-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplr;
    logic [RES_W-1:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);

`ifdef ARITH_DIV_EN
    logic             r_is_div;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    // Partial remainder shifted left with the next dividend bit brought in
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_qbit    = ~w_trial[WIDTH];
    // On a failed trial the shifted value is below the divisor, so it fits in WIDTH bits
    assign w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};
    assign res       = r_is_div ? {w_quo_nxt, w_rem_nxt} : w_acc_nxt;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_is_div <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
        end else if (start && !r_active) begin
            r_is_div <= (op == MODE_DIV);
            r_rem    <= '0;
            r_quo    <= a;
            r_dvs    <= b;
        end else if (r_active) begin
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
        end
    end
`else
    logic w_unused_op;

    assign w_unused_op = ^op;
    assign res         = w_acc_nxt;
`endif

    assign busy = r_active;
    assign fin  = r_active && (r_cnt == LAST);

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplr   <= '0;
        end else if (start && !r_active) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplr   <= b;
        end else if (r_active) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplr   <= r_mplr >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/arith_calc_module.sv
// ----------------------------------------------------------------------------
// arith_calc_module
// Four-operation integer calculator menu block (multiply, add, subtract,
// divide). Operands come from the switches on debounced BtnC pulses; the
// 32-character LCD line pair is driven on textOut.
// Optional divider: define ARITH_DIV_EN to build it. Without it mode 11
// multiplies and err is tied low.
// Ports:
//   Clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   enable   menu select; only consulted when leaving START
//   next     one-cycle button pulse
//   mode     00 mul, 01 add, 10 sub, 11 div; sampled when B is accepted
//   data_in  switch operand
//   textOut  32 ASCII characters, char 0 in [255:248]
//   result   registered result, valid while done
//   busy     high while calculating
//   done     high while the result screen is shown
//   err      divide-by-zero flag, valid while done
// ----------------------------------------------------------------------------
module arith_calc_module
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               next,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   data_in,
    output logic [LCD_W-1:0]   textOut,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned NDIG  = RES_W / 4;

    localparam logic [127:0] TXT_START_L1 = "Arithmetic Unit ";
    localparam logic [127:0] TXT_START_L2 = "Press Btnc      ";
    localparam logic [127:0] TXT_LOADA_L1 = "Input 1st #     ";
    localparam logic [127:0] TXT_LOADB_L1 = "Input 2nd #     ";
    localparam logic [127:0] TXT_PRESS_L2 = "Then Press Btnc ";
    localparam logic [127:0] TXT_CALC_L1  = "Calculating...  ";
    localparam logic [127:0] TXT_BLANK    = "                ";
    localparam logic [127:0] TXT_DIVZ_L1  = "Divide by zero  ";

    logic [4:0]       r_state, w_state_d;
    logic [WIDTH-1:0] r_a, w_a_d;
    logic [WIDTH-1:0] r_b, w_b_d;
    logic [1:0]       r_op, w_op_d;
    logic [RES_W-1:0] r_result, w_result_d;
    logic [LCD_W-1:0] r_text, w_text_d;
    logic             w_err_show;

    logic [1:0]       w_mode_eff;
    logic [WIDTH:0]   w_sum;
    logic [RES_W-1:0] w_diff;
    logic             w_eng_start;
    logic             w_eng_busy;
    logic             w_eng_fin;
    logic [RES_W-1:0] w_eng_res;
    logic [127:0]     w_line2;

`ifdef ARITH_DIV_EN
    logic r_err, w_err_d;
    logic r_dz, w_dz_d;

    assign w_mode_eff = mode;
    assign w_err_show = w_err_d;
    assign err        = r_err;
`else
    // No divider: the divide code falls back to multiply
    assign w_mode_eff = (mode == MODE_DIV) ? MODE_MUL : mode;
    assign w_err_show = 1'b0;
    assign err        = 1'b0;
`endif

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {{WIDTH{1'b0}}, r_a} - {{WIDTH{1'b0}}, r_b};

    iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter_muldiv (
        .Clk   (Clk),
        .reset (reset),
        .start (w_eng_start),
        .op    (w_mode_eff),
        .a     (r_a),
        .b     (data_in),
        .busy  (w_eng_busy),
        .fin   (w_eng_fin),
        .res   (w_eng_res)
    );

    always_comb begin
        w_state_d   = r_state;
        w_a_d       = r_a;
        w_b_d       = r_b;
        w_op_d      = r_op;
        w_result_d  = r_result;
        w_eng_start = 1'b0;
`ifdef ARITH_DIV_EN
        w_err_d     = r_err;
        w_dz_d      = r_dz;
`endif
        case (r_state)
            ST_START: begin
                w_a_d      = '0;
                w_b_d      = '0;
                w_result_d = '0;
`ifdef ARITH_DIV_EN
                w_err_d    = 1'b0;
`endif
                if (next && enable) begin
                    w_state_d = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                if (next) begin
                    w_a_d     = data_in;
                    w_state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (next) begin
                    w_b_d     = data_in;
                    w_op_d    = w_mode_eff;
                    w_state_d = ST_CALC;
`ifdef ARITH_DIV_EN
                    // A zero divisor never starts the engine; CALC finishes in one cycle
                    w_dz_d      = (w_mode_eff == MODE_DIV) && (data_in == '0);
                    w_eng_start = (w_mode_eff == MODE_MUL) ||
                                  ((w_mode_eff == MODE_DIV) && (data_in != '0));
`else
                    w_eng_start = (w_mode_eff == MODE_MUL);
`endif
                end
            end
            ST_CALC: begin
                if (r_op == MODE_ADD) begin
                    w_result_d = {{(WIDTH-1){1'b0}}, w_sum};
                    w_state_d  = ST_DONE;
                end else if (r_op == MODE_SUB) begin
                    w_result_d = w_diff;
                    w_state_d  = ST_DONE;
`ifdef ARITH_DIV_EN
                end else if (r_dz) begin
                    w_result_d = {{WIDTH{1'b1}}, r_a};
                    w_err_d    = 1'b1;
                    w_dz_d     = 1'b0;
                    w_state_d  = ST_DONE;
`endif
                end else if (w_eng_fin) begin
                    w_result_d = w_eng_res;
                    w_state_d  = ST_DONE;
                end else if (!w_eng_busy) begin
                    // Engine idle in CALC cannot occur normally; recover to the start screen
                    w_state_d  = ST_START;
                end
            end
            ST_DONE: begin
                if (next) begin
                    w_state_d  = ST_START;
                    w_a_d      = '0;
                    w_b_d      = '0;
                    w_result_d = '0;
`ifdef ARITH_DIV_EN
                    w_err_d    = 1'b0;
`endif
                end
            end
            default: begin
                w_state_d = ST_START;
            end
        endcase
    end

    // Text is computed from next-state values so it changes on the same edge as the state
    always_comb begin
        w_line2 = TXT_BLANK;
        for (int i = 0; i < NDIG; i++) begin
            w_line2[127-8*i -: 8] = bin2x(w_result_d[RES_W-1-4*i -: 4]);
        end
        case (w_state_d)
            ST_LOAD_A: w_text_d = {TXT_LOADA_L1, TXT_PRESS_L2};
            ST_LOAD_B: w_text_d = {TXT_LOADB_L1, TXT_PRESS_L2};
            ST_CALC:   w_text_d = {TXT_CALC_L1, TXT_BLANK};
            ST_DONE: begin
                if (w_err_show) begin
                    w_text_d = {TXT_DIVZ_L1, TXT_START_L2};
                end else begin
                    w_text_d = {"Result (", op_char(w_op_d), "):     ", w_line2};
                end
            end
            default:   w_text_d = {TXT_START_L1, TXT_START_L2};
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_START;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= MODE_MUL;
            r_result <= '0;
            r_text   <= {TXT_START_L1, TXT_START_L2};
`ifdef ARITH_DIV_EN
            r_err    <= 1'b0;
            r_dz     <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_d;
            r_a      <= w_a_d;
            r_b      <= w_b_d;
            r_op     <= w_op_d;
            r_result <= w_result_d;
            r_text   <= w_text_d;
`ifdef ARITH_DIV_EN
            r_err    <= w_err_d;
            r_dz     <= w_dz_d;
`endif
        end
    end

    assign textOut = r_text;
    assign result  = r_result;
    assign busy    = r_state[ST_CALC_IDX];
    assign done    = r_state[ST_DONE_IDX];

endmodule

// File: tb/tb_arith_calc_module.sv
module tb_arith_calc_module;

    localparam logic [255:0] T_START = {"Arithmetic Unit ", "Press Btnc      "};
    localparam logic [255:0] T_LOADA = {"Input 1st #     ", "Then Press Btnc "};
    localparam logic [255:0] T_MUL1  = {"Result (*):     ", "009C            "};
    localparam logic [255:0] T_ADD1  = {"Result (+):     ", "0100            "};
    localparam logic [255:0] T_SUB1  = {"Result (-):     ", "FFFE            "};
    localparam logic [255:0] T_MUL16 = {"Result (*):     ", "FFFE0001        "};
`ifdef ARITH_DIV_EN
    localparam logic [255:0] T_DIV1  = {"Result (/):     ", "1C04            "};
    localparam logic [255:0] T_DIVZ  = {"Divide by zero  ", "Press Btnc      "};
`else
    localparam logic [255:0] T_MUL3  = {"Result (*):     ", "000C            "};
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         next8, next16;
    logic [1:0]   mode8, mode16;
    logic [7:0]   d8;
    logic [15:0]  d16;
    logic [255:0] text8, text16;
    logic [15:0]  result8;
    logic [31:0]  result16;
    logic         busy8, done8, err8;
    logic         busy16, done16, err16;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    always #5 clk = ~clk;

    arith_calc_module #(.WIDTH(8)) u_dut8 (
        .Clk     (clk),
        .reset   (reset),
        .enable  (en),
        .next    (next8),
        .mode    (mode8),
        .data_in (d8),
        .textOut (text8),
        .result  (result8),
        .busy    (busy8),
        .done    (done8),
        .err     (err8)
    );

    arith_calc_module #(.WIDTH(16)) u_dut16 (
        .Clk     (clk),
        .reset   (reset),
        .enable  (en),
        .next    (next16),
        .mode    (mode16),
        .data_in (d16),
        .textOut (text16),
        .result  (result16),
        .busy    (busy16),
        .done    (done16),
        .err     (err16)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; leaves next high across exactly one rising edge
    task automatic pulse(input int t, input logic [15:0] d);
        if (t == 0) begin
            d8 = d[7:0];
            next8 = 1'b1;
        end else begin
            d16 = d;
            next16 = 1'b1;
        end
        @(negedge clk);
        next8 = 1'b0;
        next16 = 1'b0;
    endtask

    task automatic wait_done(input int t, output int n_busy);
        bit seen = 1'b0;
        n_busy = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if ((t == 0) ? done8 : done16) begin
                seen = 1'b1;
            end else begin
                if ((t == 0) ? busy8 : busy16) n_busy++;
                @(negedge clk);
            end
        end
        if (!seen) check("done_timeout", {255'd0, (t == 0) ? done8 : done16}, 256'd1);
    endtask

    // From START: enter LOAD_A, load A, load B with mode, wait for DONE
    task automatic run_calc(input int t, input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] m, output int n_busy);
        pulse(t, 16'h0);
        pulse(t, a);
        if (t == 0) mode8 = m; else mode16 = m;
        pulse(t, b);
        wait_done(t, n_busy);
    endtask

    initial begin
        reset = 1'b0;
        en = 1'b0;
        next8 = 1'b0;
        next16 = 1'b0;
        mode8 = 2'b00;
        mode16 = 2'b00;
        d8 = '0;
        d16 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        check("rst_text", text8, T_START);
        check("rst_result", {240'd0, result8}, 256'd0);
        check("rst_busy", {255'd0, busy8}, 256'd0);
        check("rst_done", {255'd0, done8}, 256'd0);
        check("rst_err", {255'd0, err8}, 256'd0);

        // enable low: next must not leave START
        pulse(0, 16'h0);
        check("en_gate_text", text8, T_START);
        en = 1'b1;

        run_calc(0, 16'h0C, 16'h0D, 2'b00, cyc);
        check("mul_cycles", 256'(cyc), 256'd8);
        check("mul_result", {240'd0, result8}, 256'h009C);
        check("mul_text", text8, T_MUL1);
        check("mul_done", {255'd0, done8}, 256'd1);
        pulse(0, 16'h0);
        check("back_start_done", {255'd0, done8}, 256'd0);

        run_calc(0, 16'hFF, 16'h01, 2'b01, cyc);
        check("add_cycles", 256'(cyc), 256'd1);
        check("add_result", {240'd0, result8}, 256'h0100);
        check("add_text", text8, T_ADD1);
        pulse(0, 16'h0);

        run_calc(0, 16'h03, 16'h05, 2'b10, cyc);
        check("sub_result", {240'd0, result8}, 256'hFFFE);
        check("sub_text", text8, T_SUB1);
        pulse(0, 16'h0);

`ifdef ARITH_DIV_EN
        run_calc(0, 16'd200, 16'd7, 2'b11, cyc);
        check("div_cycles", 256'(cyc), 256'd8);
        check("div_result", {240'd0, result8}, 256'h1C04);
        check("div_err", {255'd0, err8}, 256'd0);
        check("div_text", text8, T_DIV1);
        pulse(0, 16'h0);

        run_calc(0, 16'd200, 16'd0, 2'b11, cyc);
        check("divz_cycles", 256'(cyc), 256'd1);
        check("divz_result", {240'd0, result8}, 256'hFFC8);
        check("divz_err", {255'd0, err8}, 256'd1);
        check("divz_text", text8, T_DIVZ);
        pulse(0, 16'h0);
        check("divz_clear_err", {255'd0, err8}, 256'd0);
`else
        run_calc(0, 16'h03, 16'h04, 2'b11, cyc);
        check("mode3_cycles", 256'(cyc), 256'd8);
        check("mode3_result", {240'd0, result8}, 256'h000C);
        check("mode3_text", text8, T_MUL3);
        check("mode3_err", {255'd0, err8}, 256'd0);
        pulse(0, 16'h0);
`endif

        // next while busy is dropped
        pulse(0, 16'h0);
        pulse(0, 16'h05);
        mode8 = 2'b00;
        pulse(0, 16'h06);
        pulse(0, 16'hAA);
        wait_done(0, cyc);
        check("busy_next_result", {240'd0, result8}, 256'h001E);
        repeat (2) @(negedge clk);
        check("busy_next_not_queued", {255'd0, done8}, 256'd1);
        pulse(0, 16'h0);

        // reset during the 4th multiply cycle
        pulse(0, 16'h0);
        pulse(0, 16'h0C);
        mode8 = 2'b00;
        pulse(0, 16'h0D);
        repeat (3) @(negedge clk);
        check("pre_abort_busy", {255'd0, busy8}, 256'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", {255'd0, busy8}, 256'd0);
        check("abort_text", text8, T_START);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_result", {240'd0, result8}, 256'd0);
        check("abort_busy_after", {255'd0, busy8}, 256'd0);
        check("abort_done_after", {255'd0, done8}, 256'd0);
        pulse(0, 16'h0);
        check("restart_text", text8, T_LOADA);

        run_calc(1, 16'hFFFF, 16'hFFFF, 2'b00, cyc);
        check("w16_cycles", 256'(cyc), 256'd16);
        check("w16_result", {224'd0, result16}, 256'hFFFE0001);
        check("w16_text", text16, T_MUL16);
        pulse(1, 16'h0);
        check("w16_back_done", {255'd0, done16}, 256'd0);
        check("w16_back_text", text16, T_START);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
